// File: rtl/line_follow_drive_pkg.sv
// rtl/line_follow_drive_pkg.sv - shared H-bridge patterns, run states and sensor-half helpers
package line_follow_drive_pkg;

  localparam logic [3:0] PAT_LEFT     = 4'b1010;
  localparam logic [3:0] PAT_RIGHT    = 4'b0101;
  localparam logic [3:0] PAT_STRAIGHT = 4'b0110;
  localparam logic [3:0] PAT_STOP     = 4'b0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10,
    ST_LOST = 2'b11
  } run_state_t;

  typedef enum logic [1:0] {
    DIR_STRAIGHT = 2'd0,
    DIR_LEFT     = 2'd1,
    DIR_RIGHT    = 2'd2
  } dir_t;

  // Sensor index n_sens-1 is leftmost, so the upper half of the vector is the left side.
  function automatic logic in_left_half(input int idx, input int n_sens);
    return idx >= (n_sens / 2);
  endfunction

  function automatic logic [3:0] dir_pattern(input dir_t d);
    case (d)
      DIR_LEFT:  return PAT_LEFT;
      DIR_RIGHT: return PAT_RIGHT;
      default:   return PAT_STRAIGHT;
    endcase
  endfunction

endpackage

// File: rtl/line_follow_drive_if.sv
// rtl/line_follow_drive_if.sv - sensor/limit inputs and H-bridge outputs of the drive block
interface line_follow_drive_if #(
  parameter int N_SENS = 4
) ();

  logic              drive_en;
  logic [N_SENS-1:0] sens;
  logic              limit_a;
  logic              limit_b;
  logic [3:0]        pattern;
  logic              en_a;
  logic              en_b;
  logic [1:0]        run_state;
  logic              fault;

  modport master (
    output drive_en, sens, limit_a, limit_b,
    input  pattern, en_a, en_b, run_state, fault
  );

  modport slave (
    input  drive_en, sens, limit_a, limit_b,
    output pattern, en_a, en_b, run_state, fault
  );

endinterface

// File: rtl/line_follow_drive_pwm_ramp_channel.sv
// rtl/line_follow_drive_pwm_ramp_channel.sv - one motor side: duty ramp, limit holdoff, PWM compare
module line_follow_drive_pwm_ramp_channel #(
  parameter int PWM_W      = 8,
  parameter int RAMP_STEP  = 8,
  parameter int LIMIT_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             drive_en,
  input  logic             run,
  input  logic             limit,
  input  logic             period_start,
  input  logic [PWM_W-1:0] cnt,
  input  logic [PWM_W-1:0] target,
  output logic             en
);

  localparam int               HOLD_W = $clog2(LIMIT_HOLD + 1);
  localparam logic [PWM_W-1:0] STEP   = PWM_W'(RAMP_STEP);

  logic [PWM_W-1:0]  duty;
  logic [PWM_W-1:0]  duty_step;
  logic [PWM_W-1:0]  gap;
  logic [HOLD_W-1:0] hold;

  // Next duty one ramp step toward target, clamped so it never overshoots or wraps.
  always_comb begin
    gap       = '0;
    duty_step = duty;
    if (target > duty) begin
      gap       = target - duty;
      duty_step = duty + ((gap > STEP) ? STEP : gap);
    end else begin
      gap       = duty - target;
      duty_step = duty - ((gap > STEP) ? STEP : gap);
    end
  end

  // Limit wins over everything; holdoff counts whole periods once the limit has dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty <= '0;
      hold <= '0;
      en   <= 1'b0;
    end else if (limit) begin
      duty <= '0;
      hold <= HOLD_W'(LIMIT_HOLD);
      en   <= 1'b0;
    end else if (!drive_en) begin
      en <= 1'b0;
    end else begin
      if (period_start && hold != '0) hold <= hold - 1'b1;
      if (!run) begin
        duty <= '0;
        en   <= 1'b0;
      end else begin
        en <= duty > cnt;
        if (period_start && hold == '0) duty <= duty_step;
      end
    end
  end

endmodule

// File: rtl/line_follow_drive.sv
// rtl/line_follow_drive.sv - line-follow steering decode, run FSM, lost timer and shared PWM counter
module line_follow_drive
  import line_follow_drive_pkg::*;
#(
  parameter int N_SENS        = 4,
  parameter int PWM_W         = 8,
  parameter int DUTY_STRAIGHT = 224,
  parameter int DUTY_FAST     = 255,
  parameter int DUTY_SLOW     = 127,
  parameter int RAMP_STEP     = 8,
  parameter int LOST_PERIODS  = 64,
  parameter int LIMIT_HOLD    = 16
) (
  input logic               clk,
  input logic               rst_n,
  line_follow_drive_if.slave bus
);

  localparam logic [PWM_W-1:0] CNT_LAST = PWM_W'((1 << PWM_W) - 2);
  localparam int               LOST_W   = $clog2(LOST_PERIODS + 1);
  localparam logic [LOST_W-1:0] LOST_MAX = LOST_W'(LOST_PERIODS);

  run_state_t        state, state_nxt;
  dir_t              last_dir, dir;
  logic [PWM_W-1:0]  cnt;
  logic [LOST_W-1:0] lost_cnt;
  logic              seen_off;
  logic              period_start, all_zero, all_one, run;
  logic [PWM_W-1:0]  tgt_a, tgt_b;
  logic [3:0]        pattern_q;
  logic              en_a, en_b;
  int                cnt_l, cnt_r;

  assign period_start = (cnt == '0);
  assign all_zero     = (bus.sens == '0);
  assign all_one      = &bus.sens;
  assign run          = (state_nxt == ST_RUN);

  // Count detected (low) sensors on each half of the tape vector.
  always_comb begin
    cnt_l = 0;
    cnt_r = 0;
    for (int i = 0; i < N_SENS; i++) begin
      if (!bus.sens[i]) begin
        if (in_left_half(i, N_SENS)) cnt_l = cnt_l + 1;
        else                         cnt_r = cnt_r + 1;
      end
    end
  end

  // Steer toward the heavier side; balanced means straight, nothing seen keeps the last heading.
  always_comb begin
    dir = last_dir;
    if (cnt_l > cnt_r)      dir = DIR_LEFT;
    else if (cnt_r > cnt_l) dir = DIR_RIGHT;
    else if (cnt_l > 0)     dir = DIR_STRAIGHT;
  end

  // Per-side duty targets: inner wheel slow, outer wheel fast in a turn.
  always_comb begin
    tgt_a = PWM_W'(DUTY_STRAIGHT);
    tgt_b = PWM_W'(DUTY_STRAIGHT);
    case (dir)
      DIR_LEFT:  begin tgt_a = PWM_W'(DUTY_SLOW); tgt_b = PWM_W'(DUTY_FAST); end
      DIR_RIGHT: begin tgt_a = PWM_W'(DUTY_FAST); tgt_b = PWM_W'(DUTY_SLOW); end
      default:   ;
    endcase
  end

  // Run FSM next state; frozen whenever drive_en is low.
  always_comb begin
    state_nxt = state;
    if (bus.drive_en) begin
      case (state)
        ST_IDLE: if (all_zero) state_nxt = ST_RUN;
        ST_RUN: begin
          if (all_zero && seen_off)                                state_nxt = ST_DONE;
          else if (all_one && period_start && lost_cnt == LOST_MAX) state_nxt = ST_LOST;
        end
        ST_LOST: if (!all_one) state_nxt = ST_RUN;
        default: ;
      endcase
    end
  end

  // Run FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // PWM counter, heading memory, finish-line arming and lost-line period counter; all hold with drive_en low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      last_dir <= DIR_STRAIGHT;
      seen_off <= 1'b0;
      lost_cnt <= '0;
    end else if (bus.drive_en) begin
      cnt      <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      last_dir <= dir;
      seen_off <= (state == ST_RUN) && (seen_off || !all_zero);
      if (state != ST_RUN || !all_one)           lost_cnt <= '0;
      else if (period_start && lost_cnt != LOST_MAX) lost_cnt <= lost_cnt + 1'b1;
    end
  end

  // Direction pins follow the steering only while the FSM is (or stays) in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   pattern_q <= PAT_STOP;
    else if (bus.drive_en && run) pattern_q <= dir_pattern(dir);
    else                          pattern_q <= PAT_STOP;
  end

  line_follow_drive_pwm_ramp_channel #(
    .PWM_W(PWM_W), .RAMP_STEP(RAMP_STEP), .LIMIT_HOLD(LIMIT_HOLD)
  ) u_chan_a (
    .clk(clk), .rst_n(rst_n), .drive_en(bus.drive_en), .run(run), .limit(bus.limit_a),
    .period_start(period_start), .cnt(cnt), .target(tgt_a), .en(en_a)
  );

  line_follow_drive_pwm_ramp_channel #(
    .PWM_W(PWM_W), .RAMP_STEP(RAMP_STEP), .LIMIT_HOLD(LIMIT_HOLD)
  ) u_chan_b (
    .clk(clk), .rst_n(rst_n), .drive_en(bus.drive_en), .run(run), .limit(bus.limit_b),
    .period_start(period_start), .cnt(cnt), .target(tgt_b), .en(en_b)
  );

  assign bus.pattern   = pattern_q;
  assign bus.en_a      = en_a;
  assign bus.en_b      = en_b;
  assign bus.run_state = state;
  assign bus.fault     = (state == ST_LOST);

endmodule
